systolic_skew_feeder: RTL

//  Multi-row skewed operand feeder for the systolic array edge. Accepts one

---
 rtl/systolic_skew_feeder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/systolic_skew_feeder.sv
// Skewed operand feeder for a systolic array edge: takes one ROWS x K frame and
// serialises each row onto its own lane, with row r delayed by r*SKEW columns.
module systolic_skew_feeder #(
   parameter int ROWS       = 4,
   parameter int K          = 4,
   parameter int DATA_WIDTH = 16,
   parameter int SKEW       = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load_valid,
   output logic                         load_ready,
   input  logic [ROWS*K*DATA_WIDTH-1:0] load_data,
   input  logic                         msb_first,
   input  logic                         stall,
   output logic [ROWS*DATA_WIDTH-1:0]   row_data,
   output logic [ROWS-1:0]              row_valid,
   output logic                         busy,
   output logic                         done
);

   localparam int DW = DATA_WIDTH;
   localparam int T  = K + (ROWS - 1) * SKEW;
   localparam int TW = $clog2(T + 1);
   localparam logic [TW-1:0] T_LAST = TW'(T - 1);

   // Load handshake: a frame transfers on any edge where load_valid && load_ready.
   // load_ready is high in IDLE and on the last unstalled column of a frame,
   // so frames can follow each other with no bubble.

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                       state, state_nxt;
   logic [TW-1:0]                t;
   logic [ROWS*K*DW-1:0]         frame_buf;
   logic                         msb_q;

   logic                         last_col;
   logic                         accept;
   logic                         advance;
   logic                         finish;

   logic [ROWS*K*DW-1:0]         col_src;
   logic                         col_msb;
   logic [TW-1:0]                col_t;
   logic [ROWS*DW-1:0]           col_data;
   logic [ROWS-1:0]              col_valid;

   assign last_col = (state == RUN) && (t == T_LAST);
   assign accept   = load_valid && load_ready;
   assign advance  = (state == RUN) && !stall && !last_col;
   assign finish   = last_col && !stall;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (finish && !accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs; busy doubles as the visible state
   always_comb begin
      load_ready = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE:    load_ready = 1'b1;
         RUN: begin
            busy       = 1'b1;
            load_ready = last_col && !stall;
         end
         default: load_ready = 1'b0;
      endcase
   end

   // Column about to be registered: column 0 of the incoming frame on accept,
   // otherwise the next column of the buffered frame.
   assign col_src = accept ? load_data : frame_buf;
   assign col_msb = accept ? msb_first : msb_q;
   assign col_t   = accept ? '0 : t + TW'(1);

   always_comb begin
      col_data  = '0;
      col_valid = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int i = 0; i < K; i++) begin
            if (int'(col_t) == r * SKEW + i) begin
               col_valid[r] = 1'b1;
               if (col_msb) col_data[r*DW +: DW] = col_src[(r*K + K - 1 - i)*DW +: DW];
               else         col_data[r*DW +: DW] = col_src[(r*K + i)*DW +: DW];
            end
         end
      end
   end

   // Datapath; a stall holds t and row_data but drops row_valid and done
   always_ff @(posedge clk) begin
      if (rst) begin
         t         <= '0;
         frame_buf <= '0;
         msb_q     <= 1'b0;
         row_data  <= '0;
         row_valid <= '0;
         done      <= 1'b0;
      end else if (accept) begin
         frame_buf <= load_data;
         msb_q     <= msb_first;
         t         <= '0;
         row_data  <= col_data;
         row_valid <= col_valid;
         done      <= (col_t == T_LAST);
      end else if (advance) begin
         t         <= col_t;
         row_data  <= col_data;
         row_valid <= col_valid;
         done      <= (col_t == T_LAST);
      end else if (finish) begin
         t         <= '0;
         row_data  <= '0;
         row_valid <= '0;
         done      <= 1'b0;
      end else begin
         row_valid <= '0;
         done      <= 1'b0;
      end
   end

endmodule
